// File: rtl/adc_conversion_sequencer_if.sv
// Handshake bundle between the frame sequencer and its controller/ADC side.
// The slave modport is the sequencer's view; master is the driver's view.
interface adc_conversion_sequencer_if #(
    parameter int unsigned N_CH  = 1,
    parameter int unsigned PIX_W = 12
);
    logic              i_enable;
    logic              i_start;
    logic              i_mode;
    logic [PIX_W-1:0]  i_num_pixels;
    logic [N_CH-1:0]   i_adc_busy;
    logic [N_CH-1:0]   o_adc_start_conversion;
    logic [PIX_W-1:0]  o_pixel_index;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_overrun;

    modport slave (
        input  i_enable, i_start, i_mode, i_num_pixels, i_adc_busy,
        output o_adc_start_conversion, o_pixel_index, o_busy, o_frame_done, o_overrun
    );

    modport master (
        output i_enable, i_start, i_mode, i_num_pixels, i_adc_busy,
        input  o_adc_start_conversion, o_pixel_index, o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/adc_conversion_sequencer.sv
// Frame sequencer for the line-sensor readout: dummy lead-in, then round-robin
// ADC start pulses over the active pixels, with single/continuous frame modes.
module adc_conversion_sequencer #(
    parameter int unsigned CICLOS_FORMAS_DE_ONDA = 8,
    parameter int unsigned PRE_PIXELS            = 5,
    parameter int unsigned CONV_PERIOD           = 2,
    parameter int unsigned N_CH                  = 1,
    parameter int unsigned PIX_W                 = 12
) (
    input logic                       i_clock,
    input logic                       i_reset,
    adc_conversion_sequencer_if.slave bus
);
    localparam int unsigned LEAD_CYCLES = PRE_PIXELS * CICLOS_FORMAS_DE_ONDA - 1;
    localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {StIdle, StLead, StConvert, StDone} state_e;

    state_e            state_q;
    logic [31:0]       cnt_q;
    logic [31:0]       conv_cycles_q;
    logic [31:0]       per_q;
    logic [31:0]       pix_cyc_q;
    logic [PIX_W-1:0]  num_pix_q;
    logic [CH_W-1:0]   ch_q;
    logic [N_CH-1:0]   pulse_q;
    logic [PIX_W-1:0]  pixel_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [CH_W-1:0]   ch_nxt;
    logic              slot_free;
    logic [N_CH-1:0]   slot_pulse;
    logic [31:0]       per_nxt;

    // Slot outcome for the channel the pointer currently names.
    always_comb begin
        ch_nxt     = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
        slot_free  = ~bus.i_adc_busy[ch_q];
        slot_pulse = slot_free ? (N_CH'(1) << ch_q) : '0;
        per_nxt    = (per_q == 32'(CONV_PERIOD - 1)) ? 32'd0 : per_q + 32'd1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            conv_cycles_q <= '0;
            per_q         <= '0;
            pix_cyc_q     <= '0;
            num_pix_q     <= '0;
            ch_q          <= '0;
            pulse_q       <= '0;
            pixel_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (!bus.i_enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= '0;
            pixel_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        state_q       <= StLead;
                        cnt_q         <= '0;
                        num_pix_q     <= bus.i_num_pixels;
                        conv_cycles_q <= 32'(bus.i_num_pixels) * 32'(CICLOS_FORMAS_DE_ONDA);
                        ch_q          <= '0;
                        busy_q        <= 1'b1;
                        overrun_q     <= 1'b0;
                    end
                end
                StLead: begin
                    if (cnt_q == 32'(LEAD_CYCLES)) begin
                        if (num_pix_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            // Slot k=0 is always due on entry.
                            state_q   <= StConvert;
                            cnt_q     <= '0;
                            per_q     <= '0;
                            pix_cyc_q <= '0;
                            pixel_q   <= '0;
                            pulse_q   <= slot_pulse;
                            ch_q      <= ch_nxt;
                            if (!slot_free) overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StConvert: begin
                    if (cnt_q == conv_cycles_q - 32'd1) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pulse_q <= '0;
                        pixel_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        per_q <= per_nxt;
                        if (pix_cyc_q == 32'(CICLOS_FORMAS_DE_ONDA - 1)) begin
                            pix_cyc_q <= '0;
                            pixel_q   <= pixel_q + PIX_W'(1);
                        end else begin
                            pix_cyc_q <= pix_cyc_q + 32'd1;
                        end
                        if (per_nxt == 32'd0) begin
                            pulse_q <= slot_pulse;
                            ch_q    <= ch_nxt;
                            if (!slot_free) overrun_q <= 1'b1;
                        end else begin
                            pulse_q <= '0;
                        end
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
                    cnt_q  <= '0;
                    if (bus.i_mode) begin
                        // Continuous: re-latch the pixel count, keep busy asserted.
                        state_q       <= StLead;
                        num_pix_q     <= bus.i_num_pixels;
                        conv_cycles_q <= 32'(bus.i_num_pixels) * 32'(CICLOS_FORMAS_DE_ONDA);
                        ch_q          <= '0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_adc_start_conversion = pulse_q;
    assign bus.o_pixel_index          = pixel_q;
    assign bus.o_busy                 = busy_q;
    assign bus.o_frame_done           = done_q;
    assign bus.o_overrun              = overrun_q;
endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Drives a default-config and a 2-channel sequencer with shared stimulus and
// compares both against a frame-timeline reference model every cycle.
module tb_adc_conversion_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic        mode;
    logic [11:0] np;
    logic [1:0]  adc_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_conversion_sequencer_if #(.N_CH(1), .PIX_W(12)) ifa ();
    adc_conversion_sequencer_if #(.N_CH(2), .PIX_W(12)) ifb ();

    assign ifa.i_enable     = en;
    assign ifa.i_start      = start;
    assign ifa.i_mode       = mode;
    assign ifa.i_num_pixels = np;
    assign ifa.i_adc_busy   = adc_busy[0:0];
    assign ifb.i_enable     = en;
    assign ifb.i_start      = start;
    assign ifb.i_mode       = mode;
    assign ifb.i_num_pixels = np;
    assign ifb.i_adc_busy   = adc_busy;

    adc_conversion_sequencer #(
        .CICLOS_FORMAS_DE_ONDA(8), .PRE_PIXELS(5), .CONV_PERIOD(2), .N_CH(1), .PIX_W(12)
    ) dut_a (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (ifa)
    );

    adc_conversion_sequencer #(
        .CICLOS_FORMAS_DE_ONDA(4), .PRE_PIXELS(2), .CONV_PERIOD(2), .N_CH(2), .PIX_W(12)
    ) dut_b (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (ifb)
    );

    // Reference model state, one slot per instance.
    bit          act[2];
    int unsigned t[2];
    int unsigned n[2];
    bit          ovr[2];
    logic [1:0]  exp_pulse[2];
    int unsigned exp_pix[2];
    bit          exp_busy[2];
    bit          exp_done[2];

    function automatic int unsigned p_cic(input int i);
        return (i == 0) ? 8 : 4;
    endfunction
    function automatic int unsigned p_pre(input int i);
        return (i == 0) ? 5 : 2;
    endfunction
    function automatic int unsigned p_nch(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    localparam int unsigned PER = 2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs at cycle t of a frame follow from t alone: lead, convert slots, done.
    task automatic model_edge(input int i);
        int unsigned lead, dn, k, c;
        lead = p_pre(i) * p_cic(i) - 1;
        exp_pulse[i] = '0;
        exp_pix[i]   = 0;
        exp_done[i]  = 1'b0;
        if (rst) begin
            act[i] = 1'b0;
            ovr[i] = 1'b0;
        end else if (!en) begin
            act[i] = 1'b0;
        end else if (!act[i]) begin
            if (start) begin
                act[i] = 1'b1;
                t[i]   = 0;
                n[i]   = np;
                ovr[i] = 1'b0;
            end
        end else begin
            dn = 1 + lead + n[i] * p_cic(i);
            if (t[i] == dn) begin
                if (mode) begin
                    t[i] = 0;
                    n[i] = np;
                end else begin
                    act[i] = 1'b0;
                end
            end else begin
                t[i]++;
            end
        end
        if (act[i]) begin
            dn = 1 + lead + n[i] * p_cic(i);
            if (t[i] == dn) begin
                exp_done[i] = 1'b1;
            end else if (t[i] > lead) begin
                k = t[i] - lead - 1;
                exp_pix[i] = k / p_cic(i);
                if (k % PER == 0) begin
                    c = (k / PER) % p_nch(i);
                    if (adc_busy[c]) ovr[i] = 1'b1;
                    else exp_pulse[i] = 2'(1 << c);
                end
            end
        end
        exp_busy[i] = act[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_eq("a_pulse", 32'(ifa.o_adc_start_conversion), 32'(exp_pulse[0]));
        check_eq("a_pix", 32'(ifa.o_pixel_index), exp_pix[0]);
        check_eq("a_busy", 32'(ifa.o_busy), 32'(exp_busy[0]));
        check_eq("a_done", 32'(ifa.o_frame_done), 32'(exp_done[0]));
        check_eq("a_ovr", 32'(ifa.o_overrun), 32'(ovr[0]));
        check_eq("b_pulse", 32'(ifb.o_adc_start_conversion), 32'(exp_pulse[1]));
        check_eq("b_pix", 32'(ifb.o_pixel_index), exp_pix[1]);
        check_eq("b_busy", 32'(ifb.o_busy), 32'(exp_busy[1]));
        check_eq("b_done", 32'(ifb.o_frame_done), 32'(exp_done[1]));
        check_eq("b_ovr", 32'(ifb.o_overrun), 32'(ovr[1]));
    endtask

    task automatic run(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic start_frame(input int pixels);
        np    = 12'(pixels);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle (relative to E0) of first pulse and of frame_done on instance i.
    task automatic measure(input int i, output int first, output int done_c, output int pulses);
        first  = -1;
        done_c = -1;
        pulses = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (i == 0 ? ifa.o_adc_start_conversion[0] : |ifb.o_adc_start_conversion) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (i == 0 ? ifa.o_frame_done : ifb.o_frame_done) begin
                done_c = c;
                break;
            end
        end
    endtask

    initial begin
        int first, done_c, pulses, drops;
        rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0; np = '0; adc_busy = '0;
        run(3);
        rst = 1'b0;
        run(2);

        // Default config, N=1, single frame.
        start_frame(1);
        check_eq("t1_busy_e0", 32'(ifa.o_busy), 32'd1);
        measure(0, first, done_c, pulses);
        check_eq("t1_first_pulse", first, 40);
        check_eq("t1_done_cycle", done_c, 48);
        check_eq("t1_pulses", pulses, 4);
        tick();
        check_eq("t1_busy_off", 32'(ifa.o_busy), 32'd0);
        run(10);

        // Two-channel config, N=3.
        start_frame(3);
        measure(1, first, done_c, pulses);
        check_eq("t2_first_pulse", first, 8);
        check_eq("t2_done_cycle", done_c, 20);
        check_eq("t2_pulses", pulses, 6);
        run(60);

        // Channel 1 busy: half the slots suppressed.
        adc_busy = 2'b10;
        start_frame(3);
        measure(1, first, done_c, pulses);
        check_eq("t3_pulses", pulses, 3);
        check_eq("t3_overrun", 32'(ifb.o_overrun), 32'd1);
        run(60);
        adc_busy = 2'b00;
        start_frame(3);
        check_eq("t3_overrun_clr", 32'(ifb.o_overrun), 32'd0);
        run(80);

        // Continuous mode with a pixel-count change mid-frame.
        mode = 1'b1;
        start_frame(2);
        np = 12'd1;
        drops = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (!ifa.o_busy) drops++;
        end
        check_eq("t4_busy_drops", drops, 0);
        mode = 1'b0;
        run(70);

        // N=0: no pulses, done right after the lead.
        start_frame(0);
        measure(0, first, done_c, pulses);
        check_eq("t5_done_cycle", done_c, 40);
        check_eq("t5_pulses", pulses, 0);
        run(5);

        // Abort by enable, then by reset, each followed by a clean restart.
        start_frame(2);
        run(45);
        en = 1'b0;
        tick();
        check_eq("t6_en_busy", 32'(ifa.o_busy), 32'd0);
        en = 1'b1;
        run(5);
        start_frame(1);
        measure(0, first, done_c, pulses);
        check_eq("t6_restart_first", first, 40);
        run(5);
        start_frame(2);
        run(45);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_busy", 32'(ifa.o_busy), 32'd0);
        rst = 1'b0;
        run(3);
        start_frame(1);
        measure(0, first, done_c, pulses);
        check_eq("t6_rst_restart", done_c, 48);
        run(5);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(0, 15) == 0);
            mode     = ($urandom_range(0, 3) == 0);
            np       = 12'($urandom_range(0, 4));
            adc_busy = 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
            en       = ($urandom_range(0, 199) != 0);
            rst      = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/adc_conversion_sequencer.md
Name: adc_conversion_sequencer

Overview:
- Parametrised successor to the single-output ADC start-of-conversion pulse generator used in the line-sensor readout path.
- Replaces the external shared cycle counter with its own frame sequencer: start trigger, programmable pixel count, leading dummy pixels, configurable pulse period, N round-robin ADC channels.
- Adds single-frame and continuous modes, an ADC-busy overrun check, and frame status outputs.
- Sits between the waveform/clock generator and the ADC interface blocks.

Parameters:
- CICLOS_FORMAS_DE_ONDA, 8: clock cycles per pixel period.
- PRE_PIXELS, 5: leading dummy pixels before the conversion window (must be ≥1).
- CONV_PERIOD, 2: cycles between conversion pulses. Must divide CICLOS_FORMAS_DE_ONDA and be ≥1.
- N_CH, 1: number of ADC channels (1..8).
- PIX_W, 12: width of the pixel count and index.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable; low aborts any frame.
- i_start  in  1  frame trigger; sampled only in IDLE.
- i_mode  in  1  0 = single frame, 1 = continuous.
- i_num_pixels  in  PIX_W  active pixels per frame; latched at frame start.
- i_adc_busy  in  N_CH  per-channel ADC busy.
- o_adc_start_conversion  out  N_CH  one-cycle conversion pulses, at most one bit high.
- o_pixel_index  out  PIX_W  current active pixel (0-based).
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_overrun  out  1  sticky flag: a pulse was due while its ADC was busy.

Behaviour:
- **Reset** (i_reset=1 at an edge):
  - state=IDLE; all outputs 0; internal counters 0.
  - Reset has priority over all other inputs.
- **Enable:** i_enable=0 at any edge forces IDLE and clears o_adc_start_conversion, o_busy, o_frame_done and o_pixel_index. An aborted frame gives no o_frame_done. o_overrun is held.
- **Definitions:**
  - LEAD_CYCLES = PRE_PIXELS*CICLOS_FORMAS_DE_ONDA-1 (default 39).
  - CONV_CYCLES = N*CICLOS_FORMAS_DE_ONDA, where N = latched i_num_pixels.
  - Cycle counter: 32 bits, unsigned.
- **IDLE:**
  - If i_start=1 and i_enable=1 at edge E0: latch i_num_pixels, clear o_overrun, go to LEAD.
  - o_busy=1 from E0.
- **LEAD:**
  - Lasts LEAD_CYCLES cycles, no pulses.
  - Then go to CONVERT, or straight to DONE if N=0.
- **CONVERT:**
  - Lasts CONV_CYCLES cycles; k = 0..CONV_CYCLES-1 is the cycle index within CONVERT.
  - When k mod CONV_PERIOD = 0, a pulse j = k/CONV_PERIOD is due on channel c = j mod N_CH.
  - If i_adc_busy[c]=0, o_adc_start_conversion[c]=1 for exactly that cycle. Otherwise the pulse is suppressed and o_overrun is set.
  - The channel pointer advances in both cases.
  - o_pixel_index = k / CICLOS_FORMAS_DE_ONDA.
  - Pulses per frame: N*CICLOS_FORMAS_DE_ONDA/CONV_PERIOD.
- **DONE:**
  - Exactly one cycle; o_frame_done=1.
  - i_mode=1: back to LEAD, re-latching i_num_pixels; o_busy stays 1.
  - i_mode=0: go to IDLE; o_busy=0 from the next cycle.
  - i_mode is sampled in DONE.
- **Timing from E0:**
  - First pulse is high in the cycle after edge E0+LEAD_CYCLES+1 (default: cycle 40 after E0).
  - o_frame_done is high 1+LEAD_CYCLES+CONV_CYCLES cycles after E0.
- **Input rules:**
  - i_start outside IDLE is ignored.
  - i_num_pixels changes mid-frame are ignored.
- **Output register rules:**
  - All outputs are registered; no combinational input-to-output path.
  - The channel pointer resets to 0 at each frame start.

Test Plan:
1. Defaults, N=1, i_mode=0, i_start pulse → o_busy=1 from E0. 4 pulses on bit0 at cycles 40, 42, 44, 46 after E0. o_frame_done at cycle 48. o_busy=0 from cycle 49.
2. CICLOS=4, PRE_PIXELS=2, CONV_PERIOD=2, N_CH=2, N=3 → LEAD 7 cycles. 6 pulses alternating ch0, ch1, ch0, ch1, ch0, ch1 at 2-cycle spacing. o_pixel_index steps 0, 1, 2 every 4 cycles. o_frame_done 20 cycles after E0.
3. Test 2 config with i_adc_busy[1]=1 throughout → only 3 pulses, all ch0. o_overrun=1 from the first suppressed slot. o_overrun clears on the next i_start.
4. i_mode=1, N=2 defaults, i_num_pixels changed to 1 during frame 1 → frame 2 starts LEAD directly after DONE and uses N=1 (4 pulses). o_busy never drops.
5. N=0 → no pulses; o_frame_done 40 cycles after E0.
6. i_enable dropped mid-CONVERT, and separately i_reset mid-CONVERT → outputs 0 next cycle, no o_frame_done, state IDLE. A fresh i_start restarts with the full LEAD.
